// File: rtl/reg_bank_arbiter.sv
// Round-robin write sequencer for a D-latch storage bank: SETUP / WRITE(En) / optional HOLD framing.
// Define REG_BANK_ARB_HOLD_EN to add the HOLD state (data held one cycle after En falls).
module reg_bank_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [N-1:0]         Req,
    input  logic [N*W-1:0]       Data_in,
    output logic [N-1:0]         Gnt,
    output logic [$clog2(N)-1:0] Owner,
    output logic [W-1:0]         D_bus,
    output logic                 En,
    output logic                 Done,
    output logic                 Busy
);

    localparam int OW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;

    state_t          r_state;
    logic [OW-1:0]   r_ptr;

    logic            w_final;
    logic [N-1:0]    w_req_m;
    logic            w_found;
    logic [OW-1:0]   w_win;
    logic [OW-1:0]   w_idx;
    logic [OW-1:0]   w_ptr_nxt;
    logic [W-1:0]    w_win_data;

    function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

`ifdef REG_BANK_ARB_HOLD_EN
    assign w_final = (r_state == S_HOLD);
`else
    assign w_final = (r_state == S_WRITE);
`endif

    // The finishing owner is excluded so a lingering Req cannot re-win immediately.
    assign w_req_m = w_final ? (Req & ~onehot(Owner)) : Req;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = OW'((int'(r_ptr) + k) % N);
            if (!w_found && w_req_m[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == OW'(i)) begin
                w_win_data = Data_in[i*W +: W];
            end
        end
    end

    assign w_ptr_nxt = (w_win == OW'(N-1)) ? '0 : w_win + OW'(1);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            Gnt     <= '0;
            Owner   <= '0;
            D_bus   <= '0;
            En      <= 1'b0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            En   <= 1'b0;
            Done <= 1'b0;
            case (r_state)
                S_SETUP: begin
                    En      <= 1'b1;
`ifndef REG_BANK_ARB_HOLD_EN
                    Done    <= 1'b1;
`endif
                    r_state <= S_WRITE;
                end
`ifdef REG_BANK_ARB_HOLD_EN
                S_WRITE: begin
                    Done    <= 1'b1;
                    r_state <= S_HOLD;
                end
`endif
                // IDLE and the final state share the same arbitration point.
                default: begin
                    if (w_found) begin
                        Gnt     <= onehot(w_win);
                        Owner   <= w_win;
                        D_bus   <= w_win_data;
                        Busy    <= 1'b1;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_SETUP;
                    end else begin
                        Gnt     <= '0;
                        Busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter; expected (owner, data) pairs are queued by stimulus
// and consumed by a monitor on En/Done. Timing adapts to REG_BANK_ARB_HOLD_EN.
module tb_reg_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef REG_BANK_ARB_HOLD_EN
    localparam int TXN = 3;
`else
    localparam int TXN = 2;
`endif

    logic           clk  = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req  = '0;
    logic [N*W-1:0] din  = '0;
    logic [N-1:0]   Gnt;
    logic [1:0]     Owner;
    logic [W-1:0]   D_bus;
    logic           En;
    logic           Done;
    logic           Busy;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.N(N), .W(W)) dut (
        .CLK     (clk),
        .RSTn    (rstn),
        .Req     (req),
        .Data_in (din),
        .Gnt     (Gnt),
        .Owner   (Owner),
        .D_bus   (D_bus),
        .En      (En),
        .Done    (Done),
        .Busy    (Busy)
    );

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every En and Done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (En === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("en_unexpected", 1, 0);
            end else begin
                check("en_owner", Owner, exp_q[0].owner);
                check("en_gnt",   Gnt,   1 << exp_q[0].owner);
                check("en_dbus",  D_bus, exp_q[0].data);
            end
            check("en_single_cycle", prev_en, 0);
        end
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                check("done_owner", Owner, exp_q[0].owner);
                check("done_gnt",   Gnt,   1 << exp_q[0].owner);
                check("done_dbus",  D_bus, exp_q[0].data);
`ifdef REG_BANK_ARB_HOLD_EN
                check("done_after_en", {prev_en, En}, 2'b10);
`else
                check("done_with_en", En, 1);
`endif
                void'(exp_q.pop_front());
            end
        end
        prev_en = En;
    end

    // Advance to the next sampling point; a requester drops Req when it sees its Done.
    task automatic tick();
        @(negedge clk);
        if (Done === 1'b1) req[Owner] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with all requests pending
        rstn = 1'b0;
        req  = 4'b1111;
        for (int i = 0; i < N; i++) din[i*W +: W] = 8'(8'h11 * (i + 1));
        tick();
        tick();
        check("rst_gnt",   Gnt,   0);
        check("rst_owner", Owner, 0);
        check("rst_dbus",  D_bus, 0);
        check("rst_en",    En,    0);
        check("rst_done",  Done,  0);
        check("rst_busy",  Busy,  0);

        // Round robin: owners 0..3 back-to-back
        for (int i = 0; i < N; i++) exp_q.push_back({2'(i), 8'(8'h11 * (i + 1))});
        rstn = 1'b1;
        for (int c = 0; c < 4 * TXN; c++) begin
            tick();
            check("rr_gnt",   Gnt,   1 << (c / TXN));
            check("rr_owner", Owner, c / TXN);
            check("rr_en",    En,    (c % TXN) == 1);
            check("rr_done",  Done,  (c % TXN) == (TXN - 1));
            check("rr_busy",  Busy,  1);
        end
        tick();
        check("rr_idle_gnt",  Gnt,  0);
        check("rr_idle_busy", Busy, 0);
        check("rr_drained",   exp_q.size(), 0);

        // Single write with data changing after grant
        din[2*W +: W] = 8'hA5;
        req = 4'b0100;
        exp_q.push_back({2'd2, 8'hA5});
        tick();
        check("sw_gnt",   Gnt,   4'b0100);
        check("sw_owner", Owner, 2);
        check("sw_dbus",  D_bus, 8'hA5);
        check("sw_en",    En,    0);
        check("sw_busy",  Busy,  1);
        din[2*W +: W] = 8'h5A;
        for (int c = 1; c < TXN; c++) begin
            tick();
            check("sw_hold_dbus", D_bus, 8'hA5);
            check("sw_en_phase",  En,    c == 1);
            check("sw_done",      Done,  c == (TXN - 1));
            din[2*W +: W] = din[2*W +: W] + 8'h11;
        end
        tick();
        check("sw_idle_gnt",   Gnt,   0);
        check("sw_idle_busy",  Busy,  0);
        check("sw_idle_done",  Done,  0);
        check("sw_keep_dbus",  D_bus, 8'hA5);
        check("sw_keep_owner", Owner, 2);

        // Reset while En is high
        din[1*W +: W] = 8'h3C;
        req = 4'b0010;
        exp_q.push_back({2'd1, 8'h3C});
        tick();
        tick();
        check("rw_en_high", En, 1);
`ifdef REG_BANK_ARB_HOLD_EN
        check("rw_no_done_yet", Done, 0);
`endif
        rstn = 1'b0;
        req  = '0;
        tick();
        check("rw_en",   En,    0);
        check("rw_gnt",  Gnt,   0);
        check("rw_done", Done,  0);
        check("rw_busy", Busy,  0);
        check("rw_dbus", D_bus, 0);
        exp_q.delete();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rw_no_done", Done, 0);
        end

        // Two requesters from a fresh pointer: 1 then 3
        din[3*W +: W] = 8'h77;
        req = 4'b1010;
        exp_q.push_back({2'd1, 8'h3C});
        exp_q.push_back({2'd3, 8'h77});
        for (int c = 0; c < 2 * TXN; c++) begin
            tick();
            check("b2b_gnt", Gnt, (c < TXN) ? 4'b0010 : 4'b1000);
            check("b2b_en",  En,  (c % TXN) == 1);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        tick();
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_idle",    Busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
